rom: RTL and testbench

ROM -- requirements
Module: rom

---
 rtl/rom.sv | 79 +++++++
 tb/tb_rom.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rom.sv
// 32 x 8 constant lookup ROM with a registered, one-cycle-latency read port.
// Each word is (9*a + 3) mod 256; unknown addresses read back as 8'h00.
module rom (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [4:0] addr,
  output logic [7:0] data,
  output logic       data_valid
);

  logic [7:0] word;
  logic [7:0] data_d, data_q;
  logic       valid_d, valid_q;

  always_comb begin
    word = 8'h00;
    // An address with X/Z bits matches no entry and falls to the default.
    case (addr)
      5'd0:  word = 8'd3;
      5'd1:  word = 8'd12;
      5'd2:  word = 8'd21;
      5'd3:  word = 8'd30;
      5'd4:  word = 8'd39;
      5'd5:  word = 8'd48;
      5'd6:  word = 8'd57;
      5'd7:  word = 8'd66;
      5'd8:  word = 8'd75;
      5'd9:  word = 8'd84;
      5'd10: word = 8'd93;
      5'd11: word = 8'd102;
      5'd12: word = 8'd111;
      5'd13: word = 8'd120;
      5'd14: word = 8'd129;
      5'd15: word = 8'd138;
      5'd16: word = 8'd147;
      5'd17: word = 8'd156;
      5'd18: word = 8'd165;
      5'd19: word = 8'd174;
      5'd20: word = 8'd183;
      5'd21: word = 8'd192;
      5'd22: word = 8'd201;
      5'd23: word = 8'd210;
      5'd24: word = 8'd219;
      5'd25: word = 8'd228;
      5'd26: word = 8'd237;
      5'd27: word = 8'd246;
      5'd28: word = 8'd255;
      5'd29: word = 8'd8;
      5'd30: word = 8'd17;
      5'd31: word = 8'd26;
      default: word = 8'h00;
    endcase
  end

  // An unknown en takes the false branch of the if, so it behaves as a hold.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (en) begin
      data_d  = word;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_rom.sv
// Directed bench for rom: expected words come from the arithmetic formula and
// are queued when each read is driven, then popped one cycle later.
module tb_rom;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [4:0] addr;
  logic [7:0] data;
  logic       data_valid;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [7:0] last_data;

  rom dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .addr       (addr),
    .data       (data),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (observed running, required finished)");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_word(input logic [4:0] a);
    int v;
    if ($isunknown(a)) return 8'h00;
    v = (9 * int'(a) + 3) % 256;
    return v[7:0];
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge, then compare after the
  // next rising edge against the entry queued for it.
  task automatic step(input string tag, input logic e, input logic [4:0] a);
    logic [8:0] exp;
    @(negedge clk);
    en   = e;
    addr = a;
    if (e === 1'b1) begin
      last_data = model_word(a);
      exp_q.push_back({1'b1, last_data});
    end else begin
      exp_q.push_back({1'b0, last_data});
    end
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check8({tag, ".data"}, data, exp[7:0]);
    check1({tag, ".valid"}, data_valid, exp[8]);
  endtask

  initial begin
    en        = 1'b0;
    addr      = 5'd0;
    rst_n     = 1'b1;
    last_data = 8'h00;

    // Initial reset, asserted mid-cycle.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check8("init_reset.data", data, 8'h00);
    check1("init_reset.valid", data_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_idle", 1'b0, 5'd7);

    // Scenario 2: back-to-back reads, no bubbles.
    step("s2_a10", 1'b1, 5'd10);
    step("s2_a14", 1'b1, 5'd14);
    step("s2_a17", 1'b1, 5'd17);

    // Scenario 3: hold with addr ignored, then read the top address.
    step("s3_hold_a21", 1'b0, 5'd21);
    step("s3_hold_again", 1'b0, 5'd3);
    step("s3_a31", 1'b1, 5'd31);

    // Scenario 4.
    step("s4_a26", 1'b1, 5'd26);
    step("s4_a9",  1'b1, 5'd9);
    step("s4_a11", 1'b1, 5'd11);
    step("s4_a29", 1'b1, 5'd29);
    step("s4_a0",  1'b1, 5'd0);

    // Scenario 5: unknown address reads the default entry; unknown en holds.
    step("s5_addr_x", 1'b1, 5'bxxxxx);
    step("s5_a7", 1'b1, 5'd7);
    step("s5_en_x", 1'bx, 5'd9);

    // Scenario 1: reset in the middle of a read sequence, outputs clear at once.
    step("s1_pre_a14", 1'b1, 5'd14);
    @(negedge clk);
    en   = 1'b1;
    addr = 5'd26;
    #2;
    rst_n = 1'b0;
    #1;
    check8("s1_async.data", data, 8'h00);
    check1("s1_async.valid", data_valid, 1'b0);
    @(posedge clk);
    #1;
    check8("s1_in_reset_edge.data", data, 8'h00);
    check1("s1_in_reset_edge.valid", data_valid, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    en        = 1'b0;
    last_data = 8'h00;
    step("s1_release_idle", 1'b0, 5'd31);
    step("s1_first_read", 1'b1, 5'd21);

    // Scenario 6: exhaustive sweep.
    for (int a = 0; a < 32; a++) begin
      step($sformatf("s6_a%0d", a), 1'b1, 5'(a));
    end
    step("s6_tail_hold", 1'b0, 5'd0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
